// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and sequencer driving a combinational ALU
module alu_cmd_sequencer #(
    parameter int DATA_W     = 16,
    parameter int RES_W      = 32,
    parameter int SETTLE     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [3:0]        cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [RES_W-1:0]  alu_result,
    input  logic [1:0]        alu_error,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic [1:0]        rsp_error,
    output logic [3:0]        rsp_op,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [SET_W-1:0]    r_settle;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [3:0]          r_alu_op;
    logic                r_rsp_valid;
    logic [RES_W-1:0]    r_rsp_result;
    logic [1:0]          r_rsp_error;
    logic [3:0]          r_rsp_op;
    logic [7:0]          r_err_count;

    logic [DATA_W-1:0]   r_fifo_a  [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_fifo_b  [FIFO_DEPTH];
    logic [3:0]          r_fifo_op [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [DATA_W-1:0]   w_head_a;
    logic [DATA_W-1:0]   w_head_b;
    logic [3:0]          w_head_op;
    logic                w_head_legal;
    logic [7:0]          w_err_inc;

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid & ~w_full;
    assign w_pop     = (r_state == S_IDLE) & ~w_empty;
    assign w_head_a  = r_fifo_a[r_rd_ptr];
    assign w_head_b  = r_fifo_b[r_rd_ptr];
    assign w_head_op = r_fifo_op[r_rd_ptr];

    // add, sub, mul, div, mod occupy the contiguous range 4..8
    assign w_head_legal = (w_head_op >= 4'h4) && (w_head_op <= 4'h8);
    assign w_err_inc    = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr]  <= cmd_a;
            r_fifo_b[r_wr_ptr]  <= cmd_b;
            r_fifo_op[r_wr_ptr] <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_settle     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_error  <= '0;
            r_rsp_op     <= '0;
            r_err_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_head_legal) begin
                            r_alu_a  <= w_head_a;
                            r_alu_b  <= w_head_b;
                            r_alu_op <= w_head_op;
                            r_settle <= SET_W'(SETTLE);
                            r_state  <= S_SETTLE;
                        end else begin
                            // illegal opcodes never reach the ALU pins
                            r_rsp_result <= '0;
                            r_rsp_error  <= 2'b11;
                            r_rsp_op     <= w_head_op;
                            r_rsp_valid  <= 1'b1;
                            r_err_count  <= w_err_inc;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_SETTLE: begin
                    r_settle <= r_settle - SET_W'(1);
                    if (r_settle == SET_W'(1)) begin
                        r_rsp_result <= alu_result;
                        r_rsp_error  <= alu_error;
                        r_rsp_op     <= r_alu_op;
                        r_rsp_valid  <= 1'b1;
                        if (alu_error != 2'b00) begin
                            r_err_count <= w_err_inc;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = ~w_full;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_error  = r_rsp_error;
    assign rsp_op     = r_rsp_op;
    assign err_count  = r_err_count;
    assign busy       = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  cmd_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [1:0]  alu_error;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_error;
    logic [3:0]  rsp_op;
    logic [7:0]  err_count;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int prev_hs = 0;
    int last_hs = 0;

    logic [37:0] exp_q[$];
    logic [37:0] held;
    logic        stalled = 1'b0;

    alu_cmd_sequencer #(.DATA_W(16), .RES_W(32), .SETTLE(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .rsp_op(rsp_op),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // unsigned breadboard ALU stand-in
    always_comb begin
        alu_result = 32'd0;
        alu_error  = 2'b00;
        case (alu_op)
            4'h4: alu_result = {16'd0, alu_a} + {16'd0, alu_b};
            4'h5: alu_result = {16'd0, alu_a} - {16'd0, alu_b};
            4'h6: alu_result = {16'd0, alu_a} * {16'd0, alu_b};
            4'h7: if (alu_b == 16'd0) alu_error = 2'b10; else alu_result = {16'd0, alu_a / alu_b};
            4'h8: if (alu_b == 16'd0) alu_error = 2'b10; else alu_result = {16'd0, alu_a % alu_b};
            default: alu_result = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out, got no progress expected completion", name);
    endtask

    always @(negedge clk) begin
        if (rsp_valid && !rsp_ready) begin
            if (stalled) chk("stall_stable", {26'd0, rsp_result, rsp_error, rsp_op}, {26'd0, held});
            held    = {rsp_result, rsp_error, rsp_op};
            stalled = 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            if (stalled) chk("stall_stable", {26'd0, rsp_result, rsp_error, rsp_op}, {26'd0, held});
            stalled = 1'b0;
            prev_hs = last_hs;
            last_hs = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got %0h expected no response", {rsp_result, rsp_error, rsp_op});
            end else begin
                chk("rsp", {26'd0, rsp_result, rsp_error, rsp_op}, {26'd0, exp_q.pop_front()});
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        input logic [31:0] er, input logic [1:0] ee);
        int n = 0;
        exp_q.push_back({er, ee, op});
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!cmd_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            timeout_fail("push");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || busy) timeout_fail("drain");
    endtask

    logic [15:0] t4_a  [6] = '{16'd7, 16'd14, 16'd21, 16'd28, 16'd35, 16'd42};
    logic [15:0] t4_b  [6] = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd15, 16'd18};
    logic [3:0]  t4_op [6] = '{4'h4, 4'h6, 4'h4, 4'h6, 4'h4, 4'h6};
    logic [31:0] t4_r  [6] = '{32'd10, 32'd84, 32'd30, 32'd336, 32'd50, 32'd756};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single add, latency
        exp_q.push_back({32'd250, 2'b00, 4'h4});
        cmd_a = 16'd100; cmd_b = 16'd150; cmd_op = 4'h4; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("t1_e0_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        chk("t1_e1_alu", {alu_a, alu_b, alu_op}, {16'd100, 16'd150, 4'h4});
        chk("t1_e1_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        chk("t1_e2_rsp_valid", rsp_valid, 1);
        drain();
        chk("t1_err_count", err_count, 0);

        // 2: back-to-back sub then mul
        push(16'd200, 16'd87, 4'h5, 32'd113, 2'b00);
        push(16'd477, 16'd116, 4'h6, 32'd55332, 2'b00);
        drain();
        chk("t2_spacing", last_hs - prev_hs, 3);

        // 3: divide by zero then illegal opcode
        push(16'd21, 16'd0, 4'h7, 32'd0, 2'b10);
        push(16'd5, 16'd5, 4'h0, 32'd0, 2'b11);
        drain();
        chk("t3_err_count", err_count, 2);
        chk("t3_alu_op", alu_op, 4'h7);

        // 4: backpressure fills the FIFO
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(t4_a[i], t4_b[i], t4_op[i], t4_r[i], 2'b00);
        chk("t4_full_cmd_ready", cmd_ready, 0);
        cmd_a = t4_a[5]; cmd_b = t4_b[5]; cmd_op = t4_op[5]; cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_still_full", cmd_ready, 0);
        chk("t4_busy", busy, 1);
        rsp_ready = 1'b1;
        push(t4_a[5], t4_b[5], t4_op[5], t4_r[5], 2'b00);
        drain();

        // 5: reset while a command settles and three are queued
        rsp_ready = 1'b0;
        push(16'd1, 16'd2, 4'h4, 32'd3, 2'b00);
        for (int i = 0; i < 4; i++) push(16'd9, 16'd0, 4'h7, 32'd0, 2'b10);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        chk("t5_busy_before", busy, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_cmd_ready", cmd_ready, 1);
        chk("t5_busy", busy, 0);
        chk("t5_outputs", {alu_a, alu_b, alu_op, rsp_result, rsp_error, rsp_op, err_count}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_idle_after", busy, 0);

        // 6: saturating error counter
        for (int i = 0; i < 260; i++) push(16'(i), 16'd0, 4'h7, 32'd0, 2'b10);
        drain();
        chk("t6_err_sat", err_count, 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the 16-bit ALU breadboard interface (operands A/B, 4-bit opcode in; 32-bit result and 2-bit error out).
- Accepts operation commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the combinational ALU, waits a fixed settle time, captures result and error, and returns them in order over a valid/ready response handshake.
- Keeps a saturating error counter for the host.

Parameters:
- DATA_W, 16, operand width
- RES_W, 32, ALU result width
- SETTLE, 1, cycles operands are held before capture (minimum 1)
- FIFO_DEPTH, 4, command FIFO entries (power of 2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_a  in  DATA_W  operand A
- cmd_b  in  DATA_W  operand B
- cmd_op  in  4  ALU opcode
- alu_a  out  DATA_W  to ALU InputA, registered
- alu_b  out  DATA_W  to ALU InputB, registered
- alu_op  out  4  to ALU OpCode, registered
- alu_result  in  RES_W  from ALU Result
- alu_error  in  2  from ALU Error ([0] overflow, [1] divide/mod by zero)
- rsp_valid  out  1  response available
- rsp_ready  in  1  host accepts response
- rsp_result  out  RES_W  captured result
- rsp_error  out  2  captured error; 2'b11 means illegal opcode
- rsp_op  out  4  opcode of this response
- err_count  out  8  responses with nonzero rsp_error, saturating at 255
- busy  out  1  FSM not IDLE or FIFO non-empty

Interface decision:
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO flushed; FSM goes to IDLE.
  - All outputs 0 except cmd_ready = 1.
  - Reset mid-operation discards the in-flight command and all queued commands; no response is produced for them.
- Command FIFO:
  - Push when cmd_valid & cmd_ready.
  - cmd_ready = !full, taken from the registered count.
  - Push and pop in the same cycle is legal when not full; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Commands execute strictly in arrival order.
- Legal opcodes are 4'b0100 add, 0101 sub, 0110 mul, 0111 div, 1000 mod. All others are illegal.
- FSM states: IDLE, SETTLE, RESP.
  - IDLE, FIFO empty: stay in IDLE.
  - IDLE, FIFO non-empty: pop the head entry.
    - Legal opcode: load alu_a/alu_b/alu_op, load the settle counter with SETTLE, go to SETTLE.
    - Illegal opcode: leave alu_* unchanged, load rsp_result = 0, rsp_error = 2'b11, rsp_op = opcode, assert rsp_valid, go to RESP.
  - SETTLE: decrement the counter each cycle. On the cycle the counter equals 1, capture alu_result→rsp_result, alu_error→rsp_error, alu_op→rsp_op, assert rsp_valid, go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid & !rsp_ready. On rsp_valid & rsp_ready, deassert rsp_valid and go to IDLE. The next pop occurs no earlier than the following cycle.
- Latency, legal op with empty FIFO and SETTLE = 1:
  - Accept at edge E0, pop/drive at E1, capture at E2.
  - rsp_valid is high from E2 until the handshake.
  - Sustained throughput is one command per SETTLE+2 cycles.
- alu_a/alu_b/alu_op hold their last driven value between commands. They are never changed while in SETTLE.
- err_count increments by 1 at the capture/illegal-load edge when the loaded rsp_error != 0. It saturates at 255 and does not wrap; it is cleared only by reset.
- busy = (state != IDLE) | (count != 0).
- rsp_result is passed through unmodified. Sign extension is already performed by the ALU.

Test Plan:
1. Add, SETTLE = 1: cmd (100, 150, 0100) → alu_* driven 1 cycle after accept; rsp_valid 2 cycles after accept with rsp_result = 250, rsp_error = 00, rsp_op = 0100; err_count = 0.
2. Back-to-back commands sub (200, 87, 0101) and mul (477, 116, 0110), rsp_ready = 1 → responses in order: 113/00, then 55332/00; the second response follows the first by SETTLE+2 = 3 cycles.
3. Divide by zero (21, 0, 0111), then illegal op (5, 5, 0000) → first response rsp_error = 10; second response rsp_result = 0, rsp_error = 11, arriving 1 cycle after its pop; err_count = 2; alu_op still 0111.
4. Backpressure: rsp_ready = 0, six commands offered → first is popped, next four fill the FIFO, cmd_ready = 0 for the sixth. Release rsp_ready: all six responses arrive in order and rsp_* stay stable while stalled.
5. Reset mid-op: assert rst_n = 0 during SETTLE with 3 commands queued → outputs go to 0 immediately, cmd_ready = 1, busy = 0, and no stale response appears after release.
6. Saturation: 260 divide-by-zero commands → err_count stops at 255.
